// File: rtl/cycle_sequencer_if.sv
// Sequencer bus: memory/decoder requests in, phase counter, opcode latch and mode flags out.
interface cycle_sequencer_if;
    logic [7:0] DataBus;
    logic       Wait;
    logic       P2_Set_CM1;
    logic       P2_Set_CMR;
    logic       P2_Reset_ITABLE;
    logic       PR_Reset_XPT;
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic [7:0] ITABLE;
    logic [7:0] notITABLE;
    logic       enable;
    logic       Mode_M1;
    logic       Mode_MR;
    logic       XPT_Overrun;

    // master: memory + decoder side driving requests
    modport master (
        output DataBus, Wait, P2_Set_CM1, P2_Set_CMR, P2_Reset_ITABLE, PR_Reset_XPT,
        input  XPT, notXPT, ITABLE, notITABLE, enable, Mode_M1, Mode_MR, XPT_Overrun
    );

    modport slave (
        input  DataBus, Wait, P2_Set_CM1, P2_Set_CMR, P2_Reset_ITABLE, PR_Reset_XPT,
        output XPT, notXPT, ITABLE, notITABLE, enable, Mode_M1, Mode_MR, XPT_Overrun
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Machine-cycle sequencer (M1 fetch / EXEC / MR refresh); Wait honoured only with CYCLE_SEQUENCER_WAIT_EN.
// Latency: opcode latched 2 cycles after entering M1; decoder requests act on the next edge.
// Backpressure: Wait stalls XPT, ITABLE and state; decoder requests still take effect.
module cycle_sequencer (
    input  logic               CLK,
    input  logic               RESET,
    cycle_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {ST_M1, ST_EXEC, ST_MR} state_t;

    state_t     state, state_nxt;
    logic [3:0] xpt, xpt_nxt;
    logic [7:0] itable, itable_nxt;
    logic       ovr, ovr_nxt;
    logic       stall;
    logic       exec_req;

`ifdef CYCLE_SEQUENCER_WAIT_EN
    assign stall = bus.Wait;
`else
    logic unused_wait;
    assign unused_wait = bus.Wait;
    assign stall       = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_M1;
            xpt    <= 4'd0;
            itable <= 8'h00;
            ovr    <= 1'b0;
        end else begin
            state  <= state_nxt;
            xpt    <= xpt_nxt;
            itable <= itable_nxt;
            ovr    <= ovr_nxt;
        end
    end

    assign exec_req = bus.P2_Set_CM1 | bus.P2_Set_CMR | bus.P2_Reset_ITABLE | bus.PR_Reset_XPT;

    always_comb begin
        state_nxt  = state;
        xpt_nxt    = xpt;
        itable_nxt = itable;
        ovr_nxt    = ovr;
        case (state)
            ST_M1: begin
                if (!stall) begin
                    if (xpt == 4'd1) begin
                        itable_nxt = bus.DataBus;
                        xpt_nxt    = 4'd2;
                        state_nxt  = ST_EXEC;
                    end else begin
                        xpt_nxt = 4'd1;
                    end
                end
            end
            ST_MR: begin
                if (!stall) begin
                    if (xpt == 4'd1) begin
                        xpt_nxt   = 4'd0;
                        state_nxt = ST_M1;
                    end else begin
                        xpt_nxt = 4'd1;
                    end
                end
            end
            ST_EXEC: begin
                // Requests bypass the stall; any request suppresses the normal count step.
                if (bus.P2_Reset_ITABLE) itable_nxt = 8'h00;
                if (bus.PR_Reset_XPT)    xpt_nxt    = 4'd0;
                if (bus.P2_Set_CM1) begin
                    state_nxt = ST_M1;
                    xpt_nxt   = 4'd0;
                end else if (bus.P2_Set_CMR) begin
                    state_nxt = ST_MR;
                    xpt_nxt   = 4'd0;
                end
                if (!exec_req && !stall) begin
                    if (xpt == 4'd15) ovr_nxt = 1'b1;
                    else              xpt_nxt = xpt + 4'd1;
                end
            end
            default: begin
                state_nxt = ST_M1;
                xpt_nxt   = 4'd0;
            end
        endcase
    end

    assign bus.XPT         = xpt;
    assign bus.notXPT      = ~xpt;
    assign bus.ITABLE      = itable;
    assign bus.notITABLE   = ~itable;
    assign bus.enable      = (state == ST_EXEC);
    assign bus.Mode_M1     = (state == ST_M1);
    assign bus.Mode_MR     = (state == ST_MR);
    assign bus.XPT_Overrun = ovr;
endmodule

// File: tb/tb_cycle_sequencer.sv
// Table-driven bench for cycle_sequencer with a per-cycle expected-value scoreboard.
module tb_cycle_sequencer;
    logic CLK = 1'b0;
    logic RESET;
    cycle_sequencer_if bus();

    cycle_sequencer dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

    localparam logic [2:0] MD_M1 = 3'b100;
    localparam logic [2:0] MD_EX = 3'b010;
    localparam logic [2:0] MD_MR = 3'b001;
`ifdef CYCLE_SEQUENCER_WAIT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [7:0] data;
        logic       wt, cm1, cmr, rit, rxpt;
        logic [3:0] xpt;
        logic [7:0] it;
        logic [2:0] mode;
        logic       ov;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] xpt;
        logic [7:0] it;
        logic [2:0] mode;
        logic       ov;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   vidx   = 0;

    function automatic vec_t mk(input logic rst, input logic [7:0] d, input logic wt,
                                input logic cm1, input logic cmr, input logic rit, input logic rxpt,
                                input logic [3:0] x, input logic [7:0] it, input logic [2:0] m,
                                input logic ov);
        vec_t v;
        v.rst = rst; v.data = d; v.wt = wt; v.cm1 = cm1; v.cmr = cmr; v.rit = rit; v.rxpt = rxpt;
        v.xpt = x; v.it = it; v.mode = m; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    endtask

    task automatic step(input vec_t v);
        exp_t e, got;
        @(negedge CLK);
        RESET               = v.rst;
        bus.DataBus         = v.data;
        bus.Wait            = v.wt;
        bus.P2_Set_CM1      = v.cm1;
        bus.P2_Set_CMR      = v.cmr;
        bus.P2_Reset_ITABLE = v.rit;
        bus.PR_Reset_XPT    = v.rxpt;
        e.idx = vidx; e.xpt = v.xpt; e.it = v.it; e.mode = v.mode; e.ov = v.ov;
        sb.push_back(e);
        vidx++;
        @(posedge CLK);
        #1;
        got = sb.pop_front();
        chk("XPT",         got.idx, {4'd0, bus.XPT},    {4'd0, got.xpt});
        chk("notXPT",      got.idx, {4'd0, bus.notXPT}, {4'd0, ~got.xpt});
        chk("ITABLE",      got.idx, bus.ITABLE,         got.it);
        chk("notITABLE",   got.idx, bus.notITABLE,      ~got.it);
        chk("modes",       got.idx, {5'd0, bus.Mode_M1, bus.enable, bus.Mode_MR}, {5'd0, got.mode});
        chk("XPT_Overrun", got.idx, {7'd0, bus.XPT_Overrun}, {7'd0, got.ov});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; bus.DataBus = 8'h00; bus.Wait = 1'b0;
        bus.P2_Set_CM1 = 1'b0; bus.P2_Set_CMR = 1'b0;
        bus.P2_Reset_ITABLE = 1'b0; bus.PR_Reset_XPT = 1'b0;

        // Fetch C4, count, reset+CM1, dual request, ignored requests in M1, MR, ITABLE clear, overrun
        tbl.push_back(mk(1, 8'hC4, 0, 0, 0, 0, 0, 4'd0, 8'h00, MD_M1, 0));
        tbl.push_back(mk(0, 8'hC4, 0, 0, 0, 0, 0, 4'd1, 8'h00, MD_M1, 0));
        tbl.push_back(mk(0, 8'hC4, 0, 0, 0, 0, 0, 4'd2, 8'hC4, MD_EX, 0));
        tbl.push_back(mk(0, 8'hC4, 0, 0, 0, 0, 0, 4'd3, 8'hC4, MD_EX, 0));
        tbl.push_back(mk(0, 8'hC4, 0, 0, 0, 0, 0, 4'd4, 8'hC4, MD_EX, 0));
        tbl.push_back(mk(0, 8'hC4, 0, 0, 0, 0, 0, 4'd5, 8'hC4, MD_EX, 0));
        tbl.push_back(mk(0, 8'hC4, 0, 1, 0, 0, 1, 4'd0, 8'hC4, MD_M1, 0));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 0, 0, 4'd1, 8'hC4, MD_M1, 0));
        tbl.push_back(mk(0, 8'h5A, 0, 0, 0, 0, 0, 4'd2, 8'h5A, MD_EX, 0));
        tbl.push_back(mk(0, 8'h5A, 0, 1, 1, 0, 0, 4'd0, 8'h5A, MD_M1, 0));
        tbl.push_back(mk(0, 8'h0F, 0, 0, 1, 1, 1, 4'd1, 8'h5A, MD_M1, 0));
        tbl.push_back(mk(0, 8'h0F, 0, 0, 0, 0, 0, 4'd2, 8'h0F, MD_EX, 0));
        tbl.push_back(mk(0, 8'h0F, 0, 0, 1, 0, 0, 4'd0, 8'h0F, MD_MR, 0));
        tbl.push_back(mk(0, 8'h0F, 0, 0, 0, 0, 0, 4'd1, 8'h0F, MD_MR, 0));
        tbl.push_back(mk(0, 8'h0F, 0, 0, 0, 0, 0, 4'd0, 8'h0F, MD_M1, 0));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 0, 4'd1, 8'h0F, MD_M1, 0));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 0, 4'd2, 8'h81, MD_EX, 0));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 1, 0, 4'd2, 8'h00, MD_EX, 0));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 1, 4'd0, 8'h00, MD_EX, 0));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 0, 4'd1, 8'h00, MD_EX, 0));
        for (int i = 2; i <= 15; i++)
            tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 0, 4'(i), 8'h00, MD_EX, 0));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 0, 4'd15, 8'h00, MD_EX, 1));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 0, 4'd15, 8'h00, MD_EX, 1));
        tbl.push_back(mk(0, 8'h81, 0, 1, 0, 0, 0, 4'd0, 8'h00, MD_M1, 1));
        tbl.push_back(mk(0, 8'h81, 0, 0, 0, 0, 0, 4'd1, 8'h00, MD_M1, 1));
        tbl.push_back(mk(1, 8'h81, 0, 0, 0, 0, 0, 4'd0, 8'h00, MD_M1, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Wait held 3 cycles in EXEC at XPT=4, then a CM1 request under Wait
        step(mk(1, 8'h3C, 0, 0, 0, 0, 0, 4'd0, 8'h00, MD_M1, 0));
        step(mk(0, 8'h3C, 0, 0, 0, 0, 0, 4'd1, 8'h00, MD_M1, 0));
        step(mk(0, 8'h3C, 0, 0, 0, 0, 0, 4'd2, 8'h3C, MD_EX, 0));
        step(mk(0, 8'h3C, 0, 0, 0, 0, 0, 4'd3, 8'h3C, MD_EX, 0));
        step(mk(0, 8'h3C, 0, 0, 0, 0, 0, 4'd4, 8'h3C, MD_EX, 0));
        for (int k = 1; k <= 3; k++)
            step(mk(0, 8'h3C, 1, 0, 0, 0, 0, WEN ? 4'd4 : 4'(4 + k), 8'h3C, MD_EX, 0));
        step(mk(0, 8'h3C, 0, 0, 0, 0, 0, WEN ? 4'd5 : 4'd8, 8'h3C, MD_EX, 0));
        step(mk(0, 8'h3C, 1, 1, 0, 0, 0, 4'd0, 8'h3C, MD_M1, 0));

        // RESET in EXEC at XPT=7 with Wait high, then recovery into a fresh fetch
        step(mk(1, 8'hA7, 0, 0, 0, 0, 0, 4'd0, 8'h00, MD_M1, 0));
        step(mk(0, 8'hA7, 0, 0, 0, 0, 0, 4'd1, 8'h00, MD_M1, 0));
        step(mk(0, 8'hA7, 0, 0, 0, 0, 0, 4'd2, 8'hA7, MD_EX, 0));
        for (int k = 3; k <= 7; k++)
            step(mk(0, 8'hA7, 0, 0, 0, 0, 0, 4'(k), 8'hA7, MD_EX, 0));
        step(mk(1, 8'hA7, 1, 0, 0, 0, 0, 4'd0, 8'h00, MD_M1, 0));
        step(mk(0, 8'hA7, 0, 0, 0, 0, 0, 4'd1, 8'h00, MD_M1, 0));

        chk("sb_empty", -1, 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 DataBus  input  8  opcode byte from memory, sampled at end of fetch.
REQ-004 Wait  input  1  memory stall; freezes XPT and state while high.
REQ-005 P2_Set_CM1  input  1  from decoder: next machine cycle is opcode fetch (M1).
REQ-006 P2_Set_CMR  input  1  from decoder: next machine cycle is refresh (MR).
REQ-007 P2_Reset_ITABLE  input  1  from decoder: clear instruction latch.
REQ-008 PR_Reset_XPT  input  1  from decoder: return phase counter to 0.
REQ-009 XPT  output  4  execution phase counter.
REQ-010 notXPT  output  4  bitwise complement of XPT, same cycle.
REQ-011 ITABLE  output  8  latched opcode.
REQ-012 notITABLE  output  8  bitwise complement of ITABLE, same cycle.
REQ-013 enable  output  1  high exactly while state is EXEC.
REQ-014 Mode_M1  output  1  high while state is M1.
REQ-015 Mode_MR  output  1  high while state is MR.
REQ-016 XPT_Overrun  output  1  sticky error flag, XPT saturated.

Function
REQ-017 Three states: M1 (fetch), EXEC (decode/execute), MR (refresh); exactly one of Mode_M1, enable, Mode_MR high per cycle.
REQ-018 M1: XPT steps 0->1; on the cycle XPT==1 and Wait low, ITABLE<=DataBus, XPT<=2, state<=EXEC (fetch latency 2 cycles).
REQ-019 EXEC: XPT increments by 1 per cycle when Wait low and no decoder request.
REQ-020 EXEC: PR_Reset_XPT high -> XPT<=0 next cycle.
REQ-021 EXEC: P2_Set_CM1 high -> state<=M1 next cycle; P2_Set_CMR high -> state<=MR next cycle.
REQ-022 P2_Set_CM1 and P2_Set_CMR both high -> CM1 wins, state<=M1.
REQ-023 A state change without PR_Reset_XPT in the same cycle still forces XPT<=0 on entry to M1 or MR.
REQ-024 P2_Reset_ITABLE high -> ITABLE<=8'h00 next cycle; a simultaneous M1 latch (REQ-018) is impossible as requests are honoured only in EXEC.
REQ-025 Decoder request inputs are ignored outside EXEC.
REQ-026 Wait high freezes XPT, ITABLE and state, except PR_Reset_XPT, P2_Set_CM1, P2_Set_CMR and P2_Reset_ITABLE, which take effect regardless of Wait.
REQ-027 MR: XPT steps 0->1; at XPT==1 with Wait low, XPT<=0, state<=M1 (refresh 2 cycles).
REQ-028 EXEC with XPT==15 and no reset request: XPT holds 15 (no wrap), XPT_Overrun<=1.
REQ-029 XPT_Overrun stays set until RESET.
REQ-030 notXPT and notITABLE are purely combinational complements, never registered separately.

Reset
REQ-031 RESET high -> state M1, XPT=0, ITABLE=8'h00, XPT_Overrun=0 on next edge; Mode_M1=1, enable=0, Mode_MR=0.
REQ-032 RESET overrides every other input, including mid-fetch, mid-EXEC and during Wait.

Configuration
REQ-033 Macro CYCLE_SEQUENCER_WAIT_EN defined: Wait behaves per REQ-004/REQ-026.
REQ-034 Macro undefined: Wait port retained but ignored; sequencer behaves as if Wait is permanently low.

Verification
REQ-035 RESET 1 cycle, DataBus=8'hC4, Wait low -> XPT 0,1 in M1, then ITABLE=8'hC4, notITABLE=8'h3B, XPT=2, enable=1.
REQ-036 EXEC, XPT=5, PR_Reset_XPT and P2_Set_CM1 pulsed 1 cycle -> next cycle XPT=0, Mode_M1=1, enable=0.
REQ-037 EXEC, P2_Set_CM1 and P2_Set_CMR together -> Mode_M1=1, Mode_MR=0; separately P2_Set_CMR -> MR for 2 cycles then M1.
REQ-038 Wait held 3 cycles in EXEC at XPT=4 -> XPT stays 4, then 5 the cycle after Wait falls; with macro undefined XPT reaches 7 over the same 3 cycles.
REQ-039 EXEC with no requests for 14 cycles from XPT=2 -> XPT=15 held, XPT_Overrun=1 until RESET.
REQ-040 RESET asserted in EXEC at XPT=7 with Wait high -> XPT=0, ITABLE=8'h00, Mode_M1=1 next cycle.
